// File: rtl/full_adder.sv
// Parameterised ripple-carry full adder with sum, carry-out and signed overflow.
// Defining FULL_ADDER_OUTREG_EN adds one output register stage with async active-high reset.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  input  logic             clk,
  input  logic             rst,
  output logic             ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign carry[0] = cin;

  // One explicit 1-bit cell per bit keeps the carry chain visible to synthesis.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_c[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c = carry[WIDTH];
  assign ovf_c  = carry[WIDTH] ^ carry[WIDTH - 1];

`ifdef FULL_ADDER_OUTREG_EN
  // Output stage: reset clears immediately, otherwise capture once per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= cout_c;
      ovf  <= ovf_c;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign sum            = sum_c;
  assign cout           = cout_c;
  assign ovf            = ovf_c;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 4 and 8; covers the registered
// build as well when FULL_ADDER_OUTREG_EN is defined.
module tb_full_adder;

  typedef struct {
    string      tag;
    int         w;
    logic [9:0] exp;
  } sb_entry_t;

  logic       clk;
  logic       rst;
  logic [0:0] a1, b1, sum1;
  logic       cin1, cout1, ovf1;
  logic [3:0] a4, b4, sum4;
  logic       cin4, cout4, ovf4;
  logic [7:0] a8, b8, sum8;
  logic       cin8, cout8, ovf8;

  sb_entry_t  sb_q[$];
  int         checks;
  int         failures;

  full_adder #(.WIDTH(1)) u_dut1 (
    .a(a1), .b(b1), .cin(cin1), .cout(cout1), .sum(sum1), .clk(clk), .rst(rst), .ovf(ovf1)
  );
  full_adder #(.WIDTH(4)) u_dut4 (
    .a(a4), .b(b4), .cin(cin4), .cout(cout4), .sum(sum4), .clk(clk), .rst(rst), .ovf(ovf4)
  );
  full_adder #(.WIDTH(8)) u_dut8 (
    .a(a8), .b(b8), .cin(cin8), .cout(cout8), .sum(sum8), .clk(clk), .rst(rst), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got {ovf,cout,sum}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integer sum for sum/cout, signed range test for ovf.
  function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                       input logic c);
    int         mask;
    int         full;
    int         sa;
    int         sb;
    int         sgn;
    logic [9:0] r;
    mask = (1 << w) - 1;
    full = int'(a) & mask;
    full = full + (int'(b) & mask) + int'(c);
    sa   = (int'(a) & mask) - (a[w-1] ? (1 << w) : 0);
    sb   = (int'(b) & mask) - (b[w-1] ? (1 << w) : 0);
    sgn  = sa + sb + int'(c);
    r      = 10'd0;
    r[7:0] = 8'(full & mask);
    r[8]   = ((full >> w) & 1) == 1;
    r[9]   = (sgn > ((1 << (w - 1)) - 1)) || (sgn < -(1 << (w - 1)));
    return r;
  endfunction

  function automatic logic [9:0] observe(input int w);
    logic [9:0] r;
    r = 10'd0;
    case (w)
      1:       begin r[0:0] = sum1; r[8] = cout1; r[9] = ovf1; end
      4:       begin r[3:0] = sum4; r[8] = cout4; r[9] = ovf4; end
      default: begin r[7:0] = sum8; r[8] = cout8; r[9] = ovf8; end
    endcase
    return r;
  endfunction

  task automatic run_vec(input string tag, input int w, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
    sb_entry_t e;
`ifdef FULL_ADDER_OUTREG_EN
    @(negedge clk);
`endif
    case (w)
      1:       begin a1 = a[0:0]; b1 = b[0:0]; cin1 = c; end
      4:       begin a4 = a[3:0]; b4 = b[3:0]; cin4 = c; end
      default: begin a8 = a;      b8 = b;      cin8 = c; end
    endcase
    sb_q.push_back('{tag, w, model(w, a, b, c)});
`ifdef FULL_ADDER_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #5;
`endif
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.w), e.exp);
    end
  endtask

  initial begin
    logic [7:0] ta, tb, tc;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #12;
    check("reset_w8", observe(8), 10'd0);
    check("reset_w1", observe(1), 10'd0);
`ifdef FULL_ADDER_OUTREG_EN
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold_w4", observe(4), 10'd0);
    @(negedge clk);
`endif
    rst = 1'b0;

    // Toggle pattern: a every step, b every 2 steps, cin every 3 steps.
    for (int t = 0; t < 15; t++) begin
      ta = 8'((t / 1) % 2);
      tb = 8'((t / 2) % 2);
      tc = 8'((t / 3) % 2);
      run_vec($sformatf("toggle_t%0d", t * 10), 1, ta, tb, tc[0]);
    end

    for (int v = 0; v < 8; v++) begin
      tc = 8'(v);
      run_vec($sformatf("exh_%0d%0d%0d", tc[2], tc[1], tc[0]), 1, {7'd0, tc[0]},
              {7'd0, tc[1]}, tc[2]);
    end
    check("exh_111_const", {ovf1, cout1, 7'd0, sum1}, 10'b01_0000_0001);

    run_vec("w8_ff_01", 8, 8'hFF, 8'h01, 1'b0);
    check("w8_ff_01_const", observe(8), 10'b01_0000_0000);
    run_vec("w8_7f_01", 8, 8'h7F, 8'h01, 1'b0);
    check("w8_7f_01_const", observe(8), 10'b10_1000_0000);
    run_vec("ripple_cin0", 8, 8'hFF, 8'h00, 1'b0);
    check("ripple_cin0_const", observe(8), 10'b00_1111_1111);
    run_vec("ripple_cin1", 8, 8'hFF, 8'h00, 1'b1);
    check("ripple_cin1_const", observe(8), 10'b01_0000_0000);
    run_vec("w8_rand_a", 8, 8'h5A, 8'hC3, 1'b1);
    run_vec("w4_98_1", 4, 8'h09, 8'h08, 1'b1);
    check("w4_98_1_const", observe(4), 10'b11_0000_0010);

`ifdef FULL_ADDER_OUTREG_EN
    // Inputs changing between edges must not reach the outputs.
    #1;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    #1;
    check("reg_hold_between_edges", observe(4), 10'b11_0000_0010);
    rst = 1'b1;
    #1;
    check("reg_midop_reset", observe(4), 10'd0);
    @(posedge clk);
    #1;
    check("reg_midop_reset_after_edge", observe(4), 10'd0);
    rst = 1'b0;
`endif

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
